// File: rtl/edge_debounce_filter.sv
// Rebuilds a debounced level from one-cycle falling/rising edge pulses.
// An edge commits only after DELAY_CYC cycles with no opposing edge.
module edge_debounce_filter #(
  parameter int DELAY_CYC = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       H2L_Sig,
  input  logic       L2H_Sig,
  output logic       Filt_Sig,
  output logic       Fall_Pulse,
  output logic       Rise_Pulse,
  output logic [7:0] Bounce_Cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_HIGH   = 2'd0,
    S_WAIT_L = 2'd1,
    S_LOW    = 2'd2,
    S_WAIT_H = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_d, fall_d, rise_d;
  logic [7:0]       bcnt_d, bcnt_sat;

  assign dbg_state = state_q;
  assign bcnt_sat  = (Bounce_Cnt == 8'hFF) ? Bounce_Cnt : Bounce_Cnt + 8'd1;

  // Opposing edge in a WAIT state wins over a commit landing in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = Filt_Sig;
    fall_d  = 1'b0;
    rise_d  = 1'b0;
    bcnt_d  = Bounce_Cnt;
    case (state_q)
      S_HIGH: begin
        if (H2L_Sig && !L2H_Sig) begin
          state_d = S_WAIT_L;
          cnt_d   = '0;
        end
      end
      S_WAIT_L: begin
        if (L2H_Sig) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          bcnt_d  = bcnt_sat;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          filt_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOW: begin
        if (L2H_Sig && !H2L_Sig) begin
          state_d = S_WAIT_H;
          cnt_d   = '0;
        end
      end
      S_WAIT_H: begin
        if (H2L_Sig) begin
          state_d = S_LOW;
          cnt_d   = '0;
          bcnt_d  = bcnt_sat;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          filt_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_HIGH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_HIGH;
      cnt_q      <= '0;
      Filt_Sig   <= 1'b1;
      Fall_Pulse <= 1'b0;
      Rise_Pulse <= 1'b0;
      Bounce_Cnt <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      Filt_Sig   <= filt_d;
      Fall_Pulse <= fall_d;
      Rise_Pulse <= rise_d;
      Bounce_Cnt <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_edge_debounce_filter.sv
// Bench for edge_debounce_filter: vector table, corner sequences, random run
// against a timestamp-based reference of the debounce rules.
module tb_edge_debounce_filter;

  localparam int DELAY = 8;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       H2L_Sig = 1'b0;
  logic       L2H_Sig = 1'b0;
  logic       Filt_Sig, Fall_Pulse, Rise_Pulse;
  logic [7:0] Bounce_Cnt;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  edge_debounce_filter #(.DELAY_CYC(DELAY), .CNT_W(4)) dut (
    .CLK(CLK), .RST_n(RST_n), .H2L_Sig(H2L_Sig), .L2H_Sig(L2H_Sig),
    .Filt_Sig(Filt_Sig), .Fall_Pulse(Fall_Pulse), .Rise_Pulse(Rise_Pulse),
    .Bounce_Cnt(Bounce_Cnt), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Reference: committed level plus the cycle stamp of the pending edge.
  bit m_level, m_pend, m_fall, m_rise;
  int m_start, m_cyc, m_bcnt;

  function automatic void model_reset();
    m_level = 1'b1; m_pend = 1'b0; m_fall = 1'b0; m_rise = 1'b0;
    m_start = 0; m_cyc = 0; m_bcnt = 0;
  endfunction

  function automatic void model_edge(input bit h, input bit l);
    bit toward, opp;
    m_cyc++;
    m_fall = 1'b0;
    m_rise = 1'b0;
    toward = m_level ? h : l;
    opp    = m_level ? l : h;
    if (m_pend) begin
      if (opp) begin
        m_pend = 1'b0;
        if (m_bcnt < 255) m_bcnt++;
      end else if (m_cyc - m_start == DELAY) begin
        m_pend = 1'b0;
        if (m_level) m_fall = 1'b1; else m_rise = 1'b1;
        m_level = !m_level;
      end
    end else if (toward && !opp) begin
      m_pend  = 1'b1;
      m_start = m_cyc;
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("mdl_filt", {7'd0, Filt_Sig}, {7'd0, m_level});
    check("mdl_fall", {7'd0, Fall_Pulse}, {7'd0, m_fall});
    check("mdl_rise", {7'd0, Rise_Pulse}, {7'd0, m_rise});
    check("mdl_bcnt", Bounce_Cnt, 8'(m_bcnt));
  endtask

  // Drive one cycle of edge pulses; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic h, input logic l, input bit chk);
    H2L_Sig = h;
    L2H_Sig = l;
    @(posedge CLK);
    model_edge(h, l);
    #1;
    H2L_Sig = 1'b0;
    L2H_Sig = 1'b0;
    if (chk) check_model();
  endtask

  typedef struct {
    logic       h, l;
    logic       filt, fall, rise;
    logic [7:0] bcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic h, input logic l, input logic f,
                              input logic fp, input logic rp, input logic [7:0] b);
    vec_t v;
    v.h = h; v.l = l; v.filt = f; v.fall = fp; v.rise = rp; v.bcnt = b;
    vecs.push_back(v);
  endfunction

  initial begin
    int sel;
    // reset state, held for a few cycles
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_filt", {7'd0, Filt_Sig}, 8'd1);
    check("rst_fall", {7'd0, Fall_Pulse}, 8'd0);
    check("rst_rise", {7'd0, Rise_Pulse}, 8'd0);
    check("rst_bcnt", Bounce_Cnt, 8'd0);
    RST_n = 1'b1;
    repeat (20) step(1'b0, 1'b0, 1'b1);
    check("idle_filt", {7'd0, Filt_Sig}, 8'd1);

    // falling commit, LOW-state ignores, WAIT_H bounce, rising commit, WAIT_L bounce
    add(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < DELAY - 1; i++) add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1);
    for (int i = 0; i < DELAY - 1; i++) add(0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 0, 0, 2);
    add(0, 0, 1, 0, 0, 2);
    foreach (vecs[i]) begin
      step(vecs[i].h, vecs[i].l, 1'b0);
      check("tbl_filt", {7'd0, Filt_Sig}, {7'd0, vecs[i].filt});
      check("tbl_fall", {7'd0, Fall_Pulse}, {7'd0, vecs[i].fall});
      check("tbl_rise", {7'd0, Rise_Pulse}, {7'd0, vecs[i].rise});
      check("tbl_bcnt", Bounce_Cnt, vecs[i].bcnt);
    end

    // opposing edge arrives on the very cycle the fall would commit
    step(1'b1, 1'b0, 1'b1);
    repeat (DELAY - 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("race_filt", {7'd0, Filt_Sig}, 8'd1);
    check("race_fall", {7'd0, Fall_Pulse}, 8'd0);
    check("race_bcnt", Bounce_Cnt, 8'd3);

    // asynchronous reset in the middle of a WAIT_L count
    step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    #2;
    RST_n = 1'b0;
    #1;
    check("mid_rst_filt", {7'd0, Filt_Sig}, 8'd1);
    check("mid_rst_bcnt", Bounce_Cnt, 8'd0);
    check("mid_rst_state", {6'd0, dbg_state}, 8'd0);
    model_reset();
    #1;
    RST_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    repeat (DELAY - 1) step(1'b0, 1'b0, 1'b1);
    check("post_rst_hold", {7'd0, Filt_Sig}, 8'd1);
    step(1'b0, 1'b0, 1'b1);
    check("post_rst_fall", {7'd0, Fall_Pulse}, 8'd1);

    // saturation of the bounce counter (now in LOW: L2H then H2L bounces)
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    check("sat_bcnt", Bounce_Cnt, 8'd255);
    check("sat_filt", {7'd0, Filt_Sig}, 8'd0);

    // random pulses against the reference
    RST_n = 1'b0;
    #2;
    model_reset();
    RST_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 15);
      step(sel == 0 || sel == 2, sel == 1 || sel == 2, 1'b1);
      checks++;
      if (Fall_Pulse && Rise_Pulse) begin
        errors++;
        $display("FAIL both_pulses: fall=%0b rise=%0b required not both", Fall_Pulse, Rise_Pulse);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
